// File: rtl/udp_echo_pkg.sv
// Shared types and helpers for the UDP echo responder.
package udp_echo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_SEQ  = 2'd2
  } src_e;

  localparam int DEFAULT_DEPTH_WORDS = 256;

  // Payload bytes to 32-bit words, rounded up; the sum wraps at 16 bits.
  function automatic logic [15:0] bytes_to_words(input logic [15:0] nbytes);
    logic [15:0] sum;
    sum = nbytes + 16'd3;
    return sum >> 2;
  endfunction

endpackage

// File: rtl/udp_echo_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
module udp_echo_ram
  import udp_echo_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/udp_echo_responder.sv
// UDP echo responder: buffers one received payload and echoes it over the tx_req/tx_done handshake.
// Defining UDP_ECHO_SEQ_EN prepends a 32-bit sequence word (echo_cnt) to every echo.
// state     | meaning
// IDLE      | capture rx words, accept or drop on rec_pkt_done
// START     | pulse tx_start_en, rewind the read pointer
// SEND      | serve tx_req reads until tx_done
// WAIT_DONE | one-cycle gap before the next capture
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic [15:0] echo_cnt,
  output logic [15:0] drop_cnt
);

`ifdef UDP_ECHO_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  localparam logic [AW:0]  WR_LIMIT = (AW+1)'(DEPTH_WORDS);
  localparam logic [15:0]  NW_LIMIT = SEQ_EN ? 16'(DEPTH_WORDS - 1) : 16'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] nwords_q, nwords_d;
  logic [15:0] tx_byte_num_q, tx_byte_num_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic [15:0] echo_cnt_q, echo_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  src_e        src_q, src_d;
  logic [31:0] seq_word_q, seq_word_d;
  logic        seq_sent_q, seq_sent_d;

  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  logic        wr_full, ovf_now, drop_now;
  logic [15:0] rx_words;

  udp_echo_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (rec_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    ovf_d         = ovf_q;
    rd_ptr_d      = rd_ptr_q;
    nwords_d      = nwords_q;
    tx_byte_num_d = tx_byte_num_q;
    tx_start_d    = 1'b0;
    busy_d        = busy_q;
    echo_cnt_d    = echo_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    src_d         = src_q;
    seq_word_d    = seq_word_q;
    seq_sent_d    = seq_sent_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;

    wr_full  = (wr_ptr_q == WR_LIMIT);
    rx_words = bytes_to_words(rec_byte_num);
    // A word arriving with the end pulse belongs to this packet, so its overflow counts too.
    ovf_now  = ovf_q | (rec_en & wr_full);
    drop_now = (rec_byte_num == 16'd0) | ovf_now | (rx_words > NW_LIMIT);

    case (state_q)
      IDLE: begin
        if (rec_en) begin
          if (wr_full) begin
            ovf_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        if (rec_pkt_done) begin
          if (drop_now) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
            wr_ptr_d   = '0;
            ovf_d      = 1'b0;
          end else begin
            tx_byte_num_d = SEQ_EN ? rec_byte_num + 16'd4 : rec_byte_num;
            nwords_d      = rx_words;
            busy_d        = 1'b1;
            state_d       = START;
          end
        end
      end
      START: begin
        tx_start_d = 1'b1;
        rd_ptr_d   = '0;
        seq_sent_d = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_req) begin
          if (SEQ_EN && !seq_sent_q) begin
            src_d      = SRC_SEQ;
            seq_word_d = {16'h0000, echo_cnt_q};
            seq_sent_d = 1'b1;
          end else if (rd_ptr_q < nwords_q) begin
            src_d    = SRC_RAM;
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + 16'd1;
          end else begin
            src_d = SRC_ZERO;
          end
        end
        if (tx_done) begin
          busy_d     = 1'b0;
          echo_cnt_d = echo_cnt_q + 16'd1;
          wr_ptr_d   = '0;
          ovf_d      = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (state_q != IDLE && rec_pkt_done) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      ovf_q         <= 1'b0;
      rd_ptr_q      <= '0;
      nwords_q      <= '0;
      tx_byte_num_q <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      echo_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      src_q         <= SRC_ZERO;
      seq_word_q    <= '0;
      seq_sent_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ovf_q         <= ovf_d;
      rd_ptr_q      <= rd_ptr_d;
      nwords_q      <= nwords_d;
      tx_byte_num_q <= tx_byte_num_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      echo_cnt_q    <= echo_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      src_q         <= src_d;
      seq_word_q    <= seq_word_d;
      seq_sent_q    <= seq_sent_d;
    end
  end

  always_comb begin
    tx_data = '0;
    case (src_q)
      SRC_RAM: tx_data = ram_rdata;
      SRC_SEQ: tx_data = seq_word_q;
      default: tx_data = '0;
    endcase
  end

  assign tx_start_en = tx_start_q;
  assign tx_byte_num = tx_byte_num_q;
  assign busy        = busy_q;
  assign echo_cnt    = echo_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Bench for udp_echo_responder: transaction-level model checked every cycle plus literal spot checks.
module tb_udp_echo_responder;

  localparam int DEPTH = 256;
`ifdef UDP_ECHO_SEQ_EN
  localparam int SEQ = 1;
`else
  localparam int SEQ = 0;
`endif
  localparam int LIM = DEPTH - SEQ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        busy;
  logic [15:0] echo_cnt;
  logic [15:0] drop_cnt;

  udp_echo_responder #(.DEPTH_WORDS(DEPTH), .AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .busy         (busy),
    .echo_cnt     (echo_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a packet is either being collected, in flight, or in the post-done gap.
  logic [31:0] m_mem [DEPTH];
  int          m_wcount, m_age, m_reqs, m_nw, m_tmp;
  bit          m_ovf, m_active, m_gap;
  bit          e_busy, e_start;
  logic [15:0] e_bytes, e_echo, e_drop;
  logic [31:0] e_data;

  function automatic logic [31:0] word_at(input int k);
    int p;
    if (SEQ == 1 && k == 0) return {16'h0000, e_echo};
    p = k - SEQ;
    if (p < m_nw) return m_mem[p];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    e_start = 1'b0;
    if (rst) begin
      m_wcount = 0; m_ovf = 0; m_active = 0; m_gap = 0; m_age = 0; m_reqs = 0; m_nw = 0;
      e_busy = 0; e_bytes = 0; e_echo = 0; e_drop = 0; e_data = 0;
    end else if (m_gap) begin
      m_gap = 0;
      if (rec_pkt_done) e_drop++;
    end else if (!m_active) begin
      if (rec_en) begin
        if (m_wcount < DEPTH) begin
          m_mem[m_wcount] = rec_data;
          m_wcount++;
        end else m_ovf = 1;
      end
      if (rec_pkt_done) begin
        m_tmp = ((int'(rec_byte_num) + 3) % 65536) / 4;
        if (rec_byte_num == 0 || m_ovf || m_tmp > LIM) begin
          e_drop++;
          m_wcount = 0;
          m_ovf = 0;
        end else begin
          m_active = 1; m_age = 0; m_reqs = 0; m_nw = m_tmp;
          e_busy = 1;
          e_bytes = 16'(int'(rec_byte_num) + 4 * SEQ);
        end
      end
    end else begin
      if (rec_pkt_done) e_drop++;
      if (m_age == 0) e_start = 1;
      else begin
        if (tx_req) begin
          e_data = word_at(m_reqs);
          m_reqs++;
        end
        if (tx_done) begin
          m_active = 0; m_gap = 1; e_busy = 0; e_echo++;
          m_wcount = 0; m_ovf = 0;
        end
      end
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        32'(busy),        32'(e_busy));
      check("tx_start_en", 32'(tx_start_en), 32'(e_start));
      check("tx_byte_num", 32'(tx_byte_num), 32'(e_bytes));
      check("tx_data",     tx_data,          e_data);
      check("echo_cnt",    32'(echo_cnt),    32'(e_echo));
      check("drop_cnt",    32'(drop_cnt),    32'(e_drop));
    end
  end

  logic [31:0] pl[$];
  logic [31:0] lit_exp[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_pkt(input int bytes, input bit merge);
    for (int i = 0; i < pl.size(); i++) begin
      rec_en = 1'b1;
      rec_data = pl[i];
      if (merge && i == pl.size() - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = 16'(bytes);
      end
      tick();
    end
    rec_en = 1'b0;
    rec_data = '0;
    if (!merge || pl.size() == 0) begin
      rec_pkt_done = 1'b1;
      rec_byte_num = 16'(bytes);
      tick();
    end
    rec_pkt_done = 1'b0;
    rec_byte_num = 16'($urandom);
  endtask

  task automatic wait_start(input int bound, output int waited);
    waited = 0;
    while (!tx_start_en && waited < bound) begin
      tick();
      waited++;
    end
  endtask

  task automatic run_tx(input int nreq, input bit lit, input int abort_at, input int inject_at);
    for (int k = 0; k < nreq; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        check("rst_start", 32'(tx_start_en), 32'h0);
        check("rst_bytes", 32'(tx_byte_num), 32'h0);
        check("rst_data",  tx_data,          32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_echo",  32'(echo_cnt),    32'h0);
        check("rst_drop",  32'(drop_cnt),    32'h0);
        rst = 1'b0;
        tick();
        return;
      end
      if (!lit && $urandom_range(3) == 0) begin
        tx_req = 1'b0;
        tick();
      end
      tx_req = 1'b1;
      if (k == inject_at) begin
        rec_en = 1'b1;
        rec_data = $urandom;
        rec_pkt_done = 1'b1;
        rec_byte_num = 16'd4;
      end
      tick();
      tx_req = 1'b0;
      rec_en = 1'b0;
      rec_pkt_done = 1'b0;
      if (lit) check("lit_data", tx_data, lit_exp[k]);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int w, kind, bytes, nsend, nw;
    bit exp_start;

    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_busy",  32'(busy),     32'h0);
    check("reset_start", 32'(tx_start_en), 32'h0);
    check("reset_data",  tx_data,       32'h0);
    rst = 1'b0;
    tick();

    // basic echo of eight patterned words
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    lit_exp = {};
    if (SEQ == 1) lit_exp.push_back(32'h0);
    foreach (pl[i]) lit_exp.push_back(pl[i]);
    send_pkt(32, 1'b0);
    check("basic_busy_t1",  32'(busy),        32'h1);
    check("basic_start_t1", 32'(tx_start_en), 32'h0);
    wait_start(10, w);
    check("basic_start_latency", 32'(w), 32'h1);
    check("basic_bytes", 32'(tx_byte_num), 32'(32 + 4 * SEQ));
    check("basic_word0", pl[0], 32'h00010203);
    run_tx(8 + SEQ, 1'b1, -1, -1);
    check("basic_echo_cnt", 32'(echo_cnt), 32'h1);

    // odd length, extra request reads zero
    pl = {32'hA1B2C3D4, 32'hE5000000};
    lit_exp = {};
    if (SEQ == 1) lit_exp.push_back(32'h1);
    lit_exp.push_back(32'hA1B2C3D4);
    lit_exp.push_back(32'hE5000000);
    lit_exp.push_back(32'h0);
    send_pkt(5, 1'b1);
    wait_start(10, w);
    check("odd_bytes", 32'(tx_byte_num), 32'(5 + 4 * SEQ));
    run_tx(3 + SEQ, 1'b1, -1, -1);

    // overflow then a small packet
    pl = {};
    for (int i = 0; i < 300; i++) pl.push_back($urandom);
    send_pkt(1200, 1'b0);
    wait_start(6, w);
    check("ovf_no_start", 32'(w), 32'h6);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
    pl = {32'h12345678};
    lit_exp = {};
    if (SEQ == 1) lit_exp.push_back(32'h2);
    lit_exp.push_back(32'h12345678);
    send_pkt(4, 1'b1);
    wait_start(10, w);
    run_tx(1 + SEQ, 1'b1, -1, -1);
    check("ovf_echo_cnt", 32'(echo_cnt), 32'h3);

    // second packet arrives during SEND
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back($urandom);
    lit_exp = {};
    if (SEQ == 1) lit_exp.push_back(32'h3);
    foreach (pl[i]) lit_exp.push_back(pl[i]);
    send_pkt(32, 1'b0);
    wait_start(10, w);
    run_tx(8 + SEQ, 1'b1, -1, 4);
    check("busydrop_drop_cnt", 32'(drop_cnt), 32'h2);

    // reset after three reads
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back($urandom);
    send_pkt(32, 1'b1);
    wait_start(10, w);
    run_tx(8 + SEQ, 1'b0, 3, -1);

    // two fresh 4-byte packets
    for (int p = 0; p < 2; p++) begin
      pl = {32'hCAFE0001 + 32'(p)};
      lit_exp = {};
      if (SEQ == 1) lit_exp.push_back(32'(p));
      lit_exp.push_back(32'hCAFE0001 + 32'(p));
      send_pkt(4, 1'b0);
      wait_start(10, w);
      check("fresh_bytes", 32'(tx_byte_num), 32'(4 + 4 * SEQ));
      run_tx(1 + SEQ, 1'b1, -1, -1);
    end
    check("fresh_echo_cnt", 32'(echo_cnt), 32'h2);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(9);
      if (kind == 0) begin
        bytes = 0;
        nsend = $urandom_range(2);
      end else if (kind == 1) begin
        bytes = $urandom_range(4000, 1100);
        nsend = $urandom_range(3, 1);
      end else begin
        bytes = $urandom_range(128, 1);
        nsend = (bytes + 3) / 4;
      end
      nw = (bytes + 3) / 4;
      pl = {};
      for (int i = 0; i < nsend; i++) pl.push_back($urandom);
      exp_start = (bytes != 0) && (nw <= LIM);
      send_pkt(bytes, 1'($urandom_range(1)));
      wait_start(exp_start ? 10 : 4, w);
      if (exp_start) begin
        check("rnd_start", 32'(tx_start_en), 32'h1);
        if (tx_start_en)
          run_tx(nw + SEQ + $urandom_range(2), 1'b0, -1, ($urandom_range(4) == 0) ? 0 : -1);
      end else begin
        check("rnd_nostart", 32'(tx_start_en), 32'h0);
      end
      repeat ($urandom_range(3, 1)) tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
